// File: rtl/viterbi_frame_ctrl_if.sv
// rtl/viterbi_frame_ctrl_if.sv - payload byte stream into the frame controller
interface viterbi_frame_ctrl_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - frame sequencer feeding the convolutional encoder and checking the Viterbi decoder output
module viterbi_frame_ctrl #(
    parameter int FRAME_BYTES = 16,
    parameter int TAIL_BITS   = 2,
    parameter int DEC_LAT     = 12,
    parameter int ERR_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    viterbi_frame_ctrl_if.slave   s_if,
    output logic                  enc_bit_o,
    output logic                  enc_en_o,
    input  logic                  dec_bit_i,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [15:0]           frame_cnt
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TAIL  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES);
    localparam logic [3:0] TAIL_LAST = 4'(TAIL_BITS - 1);

    logic [2:0]         state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [3:0]         tail_cnt_q, tail_cnt_d;
    logic [15:0]        frame_q, frame_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [DEC_LAT-1:0] chk_q, chk_d;
    logic [DEC_LAT-1:0] bit_q, bit_d;

    logic accept;
    logic clr_err;
    logic mismatch;

    assign enc_en_o  = (state_q == ST_SHIFT) || (state_q == ST_TAIL);
    assign enc_bit_o = (state_q == ST_SHIFT) ? byte_q[bit_idx_q] : 1'b0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err_cnt   = 16'(err_q);
    assign frame_cnt = frame_q;

    // A new byte may be taken on the last bit of the current one so the encoder sees no bubble.
    assign s_if.s_ready = (state_q == ST_LOAD) ||
                          ((state_q == ST_SHIFT) && (bit_idx_q == 3'd7) && (byte_cnt_q != LAST_BYTE));
    assign accept = s_if.s_valid && s_if.s_ready;

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        byte_cnt_d = byte_cnt_q;
        bit_idx_d  = bit_idx_q;
        tail_cnt_d = tail_cnt_q;
        frame_d    = frame_q;
        clr_err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_err    = 1'b1;
                    byte_cnt_d = 8'd0;
                    bit_idx_d  = 3'd0;
                    tail_cnt_d = 4'd0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    byte_d     = s_if.s_data;
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    bit_idx_d  = 3'd0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    if (accept) begin
                        byte_d     = s_if.s_data;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end else if (byte_cnt_q == LAST_BYTE) begin
                        state_d = (TAIL_BITS == 0) ? ST_DRAIN : ST_TAIL;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_TAIL: begin
                tail_cnt_d = tail_cnt_q + 4'd1;
                if (tail_cnt_q == TAIL_LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!(|chk_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_d = frame_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 0 takes the bit just sent; the top stage lines up with dec_bit_i DEC_LAT cycles later.
    assign chk_d    = (chk_q << 1) | DEC_LAT'(state_q == ST_SHIFT);
    assign bit_d    = (bit_q << 1) | DEC_LAT'(enc_bit_o);
    assign mismatch = chk_q[DEC_LAT-1] && (bit_q[DEC_LAT-1] != dec_bit_i);

    always_comb begin
        err_d = err_q;
        if (clr_err) begin
            err_d = '0;
        end else if (mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            byte_q     <= 8'd0;
            byte_cnt_q <= 8'd0;
            bit_idx_q  <= 3'd0;
            tail_cnt_q <= 4'd0;
            frame_q    <= 16'd0;
            err_q      <= '0;
            chk_q      <= '0;
            bit_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            byte_cnt_q <= byte_cnt_d;
            bit_idx_q  <= bit_idx_d;
            tail_cnt_q <= tail_cnt_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            chk_q      <= chk_d;
            bit_q      <= bit_d;
        end
    end
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - self-checking bench for viterbi_frame_ctrl
module tb_viterbi_frame_ctrl;
    localparam int FB = 2;
    localparam int TB = 2;
    localparam int DL = 12;
    localparam int HN = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dec_bit = 1'b0;
    logic        enc_bit, enc_en, busy, done;
    logic [15:0] err_cnt, frame_cnt;

    logic        start2 = 1'b0;
    logic        dec2 = 1'b1;
    logic        enc_bit2, enc_en2, busy2, done2;
    logic [15:0] err2, frame2;

    viterbi_frame_ctrl_if sif ();
    viterbi_frame_ctrl_if sif2 ();

    viterbi_frame_ctrl #(.FRAME_BYTES(FB), .TAIL_BITS(TB), .DEC_LAT(DL), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .s_if(sif),
        .enc_bit_o(enc_bit), .enc_en_o(enc_en), .dec_bit_i(dec_bit),
        .busy(busy), .done(done), .err_cnt(err_cnt), .frame_cnt(frame_cnt)
    );

    // Narrow error counter so saturation is reachable inside one short frame.
    viterbi_frame_ctrl #(.FRAME_BYTES(2), .TAIL_BITS(0), .DEC_LAT(3), .ERR_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .s_if(sif2),
        .enc_bit_o(enc_bit2), .enc_en_o(enc_en2), .dec_bit_i(dec2),
        .busy(busy2), .done(done2), .err_cnt(err2), .frame_cnt(frame2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model state
    logic [7:0]  frame_data [0:FB-1];
    bit          exp_q [$];
    bit          h_b [0:HN-1];
    int          h_pos [0:HN-1];
    bit          m_active = 1'b0;
    logic [15:0] m_err = 16'd0;
    logic [15:0] m_frame = 16'd0;
    int          m_done = -1;
    int          m_pos = 0;
    int          m_rst = -1;
    int          inj_a = -1;
    int          inj_b = -1;
    bit          inj_tail = 1'b0;

    // Observations pinned against hand-computed literals
    logic [15:0] cap_bits;
    int          cap_n, first_en, gap, gap_rdy, done_cyc, st;

    always @(negedge clk) begin : compare
        int c;
        bit eb;
        c = cyc;
        if (!rst) begin
            m_active = 1'b0; m_err = 16'd0; m_frame = 16'd0; m_done = -1; m_pos = 0; m_rst = c;
            exp_q.delete();
            h_b[c] = 1'b0; h_pos[c] = -1;
            chk("rst_s_ready", sif.s_ready, 0);
            chk("rst_enc_en", enc_en, 0);
            chk("rst_enc_bit", enc_bit, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
        end else begin
            if (enc_en) begin
                chk("enc_en_expected", exp_q.size() > 0, 1);
                eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                chk("enc_bit", enc_bit, eb);
                h_b[c] = eb;
                h_pos[c] = (m_pos < 8*FB) ? m_pos : -1;
                if (m_pos == 8*FB-1) m_done = c + ((DL > TB) ? DL : TB) + 2;
                m_pos++;
            end else begin
                chk("enc_bit_gated", enc_bit, 0);
                h_b[c] = 1'b0; h_pos[c] = -1;
            end
            chk("busy", busy, m_active);
            chk("done", done, c == m_done);
            chk("err_cnt", err_cnt, m_err);
            chk("frame_cnt", frame_cnt, m_frame);
            chk("s_ready_idle", sif.s_ready && !m_active, 0);
            if (c >= DL && (c - DL) > m_rst && h_pos[c-DL] >= 0 &&
                dec_bit != h_b[c-DL] && m_err != 16'hFFFF) m_err++;
            if (c == m_done) begin
                m_frame++; m_active = 1'b0; m_done = -1;
            end else if (start && !m_active) begin
                m_active = 1'b1; m_err = 16'd0; m_pos = 0;
                exp_q.delete();
                for (int i = 0; i < FB; i++)
                    for (int j = 0; j < 8; j++) exp_q.push_back(frame_data[i][j]);
                for (int k = 0; k < TB; k++) exp_q.push_back(1'b0);
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (rst && start && !busy) begin
            cap_bits = 16'd0; cap_n = 0; first_en = -1; gap = 0; gap_rdy = 0; done_cyc = -1; st = cyc;
        end else if (rst) begin
            if (enc_en && cap_n < 8*FB) begin
                if (first_en < 0) first_en = cyc - st;
                cap_bits = {cap_bits[14:0], enc_bit};
                cap_n++;
            end else if (!enc_en && busy && cap_n > 0 && cap_n < 8*FB) begin
                gap++;
                if (sif.s_ready) gap_rdy++;
            end
            if (done) done_cyc = cyc - st;
        end
    end

    // Channel: replay the model's transmitted bits DL cycles later, inverting selected ones.
    always @(posedge clk) begin : dec_drv
        int k;
        bit inv;
        #1;
        k = cyc - DL;
        if (k >= 0) begin
            if (h_pos[k] >= 0) inv = (h_pos[k] == inj_a) || (h_pos[k] == inj_b);
            else inv = inj_tail;
            dec_bit = h_b[k] ^ inv;
        end
    end

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int stall);
        bit ok;
        bit got;
        frame_data[0] = b0; frame_data[1] = b1;
        start = 1'b1;
        sif.s_data = b0; sif.s_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < FB; i++) begin
            sif.s_data = frame_data[i]; sif.s_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 64 && !ok; t++) begin
                @(negedge clk); ok = sif.s_ready;
                @(posedge clk); #1;
            end
            chk("byte_accepted", ok, 1);
            if (i == 0 && stall > 0) begin
                sif.s_valid = 1'b0;
                repeat (7 + stall) @(posedge clk);
                #1;
            end
        end
        sif.s_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); got = done;
        end
        chk("done_seen", got, 1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int s2;
        int d2;
        for (int i = 0; i < HN; i++) begin h_b[i] = 1'b0; h_pos[i] = -1; end
        sif.s_data = 8'd0; sif.s_valid = 1'b0;
        sif2.s_data = 8'd0; sif2.s_valid = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean channel
        run_frame(8'hA5, 8'h3C, 0);
        chk("t1_bits", cap_bits, 16'hA53C);
        chk("t1_first_shift", first_en, 2);
        chk("t1_gap", gap, 0);
        chk("t1_done_cycle", done_cyc, 31);
        chk("t1_err", err_cnt, 0);
        chk("t1_frames", frame_cnt, 1);

        // Injected errors on checked positions 3 and 9, plus inversions on unchecked bits
        inj_a = 3; inj_b = 9; inj_tail = 1'b1;
        run_frame(8'hA5, 8'h3C, 0);
        chk("t2_err", err_cnt, 2);
        chk("t2_frames", frame_cnt, 2);
        inj_a = -1; inj_b = -1; inj_tail = 1'b0;

        // Back-pressure after the first byte
        run_frame(8'h03, 8'h10, 5);
        chk("t3_bits", cap_bits, 16'hC008);
        chk("t3_gap", gap, 5);
        chk("t3_gap_ready", gap_rdy, 5);
        chk("t3_done_cycle", done_cyc, 36);
        chk("t3_err", err_cnt, 0);
        chk("t3_frames", frame_cnt, 3);

        // Reset in the middle of SHIFT
        frame_data[0] = 8'hA5; frame_data[1] = 8'h3C;
        start = 1'b1; sif.s_data = 8'hA5; sif.s_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_enc_en_pre", enc_en, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_frames", frame_cnt, 0);
        rst = 1'b1; sif.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_idle_done", done, 0);
        run_frame(8'hA5, 8'h3C, 0);
        chk("t5_err", err_cnt, 0);
        chk("t5_frames", frame_cnt, 1);
        chk("t5_done_cycle", done_cyc, 31);

        // Protocol: stray starts in SHIFT and DONE, then back-to-back frames
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        inj_a = 1;
        fork
            run_frame(8'h5A, 8'hC3, 0);
            begin
                repeat (5) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                repeat (25) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
        join
        chk("t4_err_first", err_cnt, 1);
        chk("t4_frames_first", frame_cnt, 1);
        chk("t4_done_cycle", done_cyc, 31);
        inj_a = -1;
        run_frame(8'hFF, 8'h00, 0);
        chk("t4_err_second", err_cnt, 0);
        chk("t4_frames", frame_cnt, 2);

        // Saturation on the narrow build: 16 mismatches against a 4-bit counter
        sif2.s_data = 8'h00; sif2.s_valid = 1'b1; dec2 = 1'b1;
        start2 = 1'b1; s2 = cyc;
        @(posedge clk); #1 start2 = 1'b0;
        d2 = -1;
        for (int t = 0; t < 100 && d2 < 0; t++) begin
            @(negedge clk);
            if (cyc - s2 == 19) chk("sat_err_14", err2, 14);
            if (cyc - s2 == 20) chk("sat_err_15", err2, 15);
            if (cyc - s2 == 21) chk("sat_err_hold", err2, 15);
            if (done2) d2 = cyc - s2;
        end
        chk("sat_done_cycle", d2, 22);
        @(posedge clk); #1;
        sif2.s_valid = 1'b0;
        chk("sat_err_final", err2, 16'h000F);
        chk("sat_frames", frame2, 1);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
